write_back_unit: RTL
====================

WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, register/datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  MEM-stage instruction offered.
REQ-006 SHALL have port in_ready  out  1  unit accepts the offered instruction this cycle.
REQ-007 SHALL have port in_reg_write  in  1  instruction writes a register.
REQ-008 SHALL have port in_rd  in  REG_AW  destination register.
REQ-009 SHALL have port in_wb_sel  in  2  source select: ALU=0, MEM=1, PC4=2, IMM=3.
REQ-010 SHALL have ports in_alu_result, in_pc_plus4, in_imm  in  XLEN each  candidate results.
REQ-011 SHALL have port in_load_funct3  in  3  load type (RV encoding).
REQ-012 SHALL have port in_addr_low  in  3  low byte-address bits of the load.
REQ-013 SHALL have ports mem_rsp_valid  in  1 and mem_rsp_data  in  XLEN  aligned memory read response.
REQ-014 SHALL have port flush  in  1  discard in-flight instruction.
REQ-015 SHALL have ports rf_we  out  1, rf_waddr  out  REG_AW, rf_wdata  out  XLEN  register-file write port.
REQ-016 SHALL have ports load_fault  out  1 (misaligned/illegal load) and stray_rsp  out  1 (unexpected response), single-cycle pulses.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_MEM, DRAIN.
REQ-018 SHALL drive in_ready=1 in IDLE, 0 in WAIT_MEM and DRAIN.
REQ-019 Accept = in_valid & in_ready & ~flush; a flush-cycle offer SHALL be dropped.
REQ-020 Accepted non-MEM instruction SHALL produce rf_we=1 on the following cycle (latency 1), state stays IDLE.
REQ-021 Accepted MEM instruction SHALL latch rd/funct3/addr_low and go IDLE->WAIT_MEM; no write yet.
REQ-022 In WAIT_MEM, mem_rsp_valid SHALL produce the extracted load write on the next cycle and return to IDLE.
REQ-023 Load extraction: LB/LBU byte lane addr_low, LH/LHU halfword lane addr_low[2:1], LW word lane addr_low[2], sign- or zero-extended to XLEN; LD (011) and LWU (110) legal only when XLEN=64.
REQ-024 Misaligned (LH/LHU addr_low[0]=1; LW/LWU addr_low[1:0]!=0; LD addr_low!=0) or illegal funct3 SHALL suppress the write and pulse load_fault on the cycle rf_we would have risen.
REQ-025 rf_we SHALL be 0 whenever rd==0 or in_reg_write==0; rf_waddr/rf_wdata SHALL still update.
REQ-026 Flush in WAIT_MEM without same-cycle response SHALL go to DRAIN; first mem_rsp_valid in DRAIN SHALL be discarded, then IDLE.
REQ-027 Flush in WAIT_MEM coincident with mem_rsp_valid SHALL discard the response and go to IDLE.
REQ-028 Flush in IDLE SHALL cancel the write produced by the previous cycle's accept (rf_we forced 0 that cycle is NOT required; writes already registered SHALL complete).
REQ-029 mem_rsp_valid in IDLE SHALL be ignored and pulse stray_rsp next cycle.
REQ-030 rf_we, load_fault, stray_rsp SHALL be registered single-cycle pulses.

Reset
REQ-031 reset SHALL force state IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, load_fault=0, stray_rsp=0, in_ready=1 next cycle.
REQ-032 Reset in WAIT_MEM/DRAIN SHALL abandon the pending load with no write; later responses follow REQ-029.

Structure
REQ-033 Package wb_pkg SHALL hold wb_sel_e enum, load funct3 constants, and wb_state_e enum.
REQ-034 Combinational sub-module load_align SHALL perform lane selection, extension and fault detection (REQ-023/024).

Verification
REQ-035 ALU op rd=5, alu=0x1234_5678 accepted cycle N -> rf_we=1, waddr=5, wdata=0x1234_5678 at N+1.
REQ-036 LB rd=3, addr_low=2, rsp=0x0080_0000 -> wdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-037 LH addr_low=1 -> no write, load_fault pulse 1 cycle after response.
REQ-038 Load then flush 1 cycle later, rsp 3 cycles later -> DRAIN, no rf_we, in_ready=1 cycle after rsp.
REQ-039 ALU op rd=0 -> rf_we=0; mem_rsp_valid in IDLE -> stray_rsp pulse, no write.
REQ-040 XLEN=64: LD addr_low=0, rsp=0x8000_0000_0000_0001 -> wdata identical; LWU addr_low=4 -> upper word zero-extended.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: result-source select, load funct3
// encodings and the load-tracking FSM states.
package wb_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      DRAIN    = 2'd2
   } wb_state_e;

endpackage

// File: rtl/write_back_unit_if.sv
// MEM-stage offer, memory response, flush and register-file write port of the
// write-back unit; master drives the stage inputs, slave is the unit itself.
interface write_back_unit_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic              in_reg_write;
   logic [REG_AW-1:0] in_rd;
   logic [1:0]        in_wb_sel;
   logic [XLEN-1:0]   in_alu_result;
   logic [XLEN-1:0]   in_pc_plus4;
   logic [XLEN-1:0]   in_imm;
   logic [2:0]        in_load_funct3;
   logic [2:0]        in_addr_low;
   logic              mem_rsp_valid;
   logic [XLEN-1:0]   mem_rsp_data;
   logic              flush;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [XLEN-1:0]   rf_wdata;
   logic              load_fault;
   logic              stray_rsp;

   modport master (
      output in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result,
             in_pc_plus4, in_imm, in_load_funct3, in_addr_low,
             mem_rsp_valid, mem_rsp_data, flush,
      input  in_ready, rf_we, rf_waddr, rf_wdata, load_fault, stray_rsp
   );

   modport slave (
      input  in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result,
             in_pc_plus4, in_imm, in_load_funct3, in_addr_low,
             mem_rsp_valid, mem_rsp_data, flush,
      output in_ready, rf_we, rf_waddr, rf_wdata, load_fault, stray_rsp
   );
endinterface

// File: rtl/load_align.sv
// Combinational load lane select + sign/zero extension, flagging misaligned
// or XLEN-illegal load encodings.
module load_align
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [2:0]      addr_low,
   input  logic [XLEN-1:0] rsp_data,
   output logic [XLEN-1:0] result,
   output logic            fault
);
   localparam bit IS64 = (XLEN == 64);

   logic [2:0]      lane;
   logic [XLEN-1:0] shifted;
   logic [7:0]      b;
   logic [15:0]     h;
   logic [31:0]     w;

   always_comb begin
      // A 32-bit response has only four byte lanes, so addr_low[2] is ignored.
      lane    = IS64 ? addr_low : {1'b0, addr_low[1:0]};
      shifted = rsp_data >> {lane, 3'b000};
      b       = shifted[7:0];
      h       = shifted[15:0];
      w       = shifted[31:0];
      result  = '0;
      fault   = 1'b0;
      case (funct3)
         F3_LB:  result = XLEN'($signed(b));
         F3_LBU: result = XLEN'(b);
         F3_LH:  begin result = XLEN'($signed(h)); fault = addr_low[0]; end
         F3_LHU: begin result = XLEN'(h);          fault = addr_low[0]; end
         F3_LW:  begin result = XLEN'($signed(w)); fault = (addr_low[1:0] != 2'b00); end
         F3_LWU: begin result = XLEN'(w);          fault = !IS64 || (addr_low[1:0] != 2'b00); end
         F3_LD:  begin result = shifted;           fault = !IS64 || (addr_low != 3'b000); end
         default: fault = 1'b1;
      endcase
   end
endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: non-load results written 1 cycle after accept; loads wait
// for the memory response, with flush/DRAIN handling for abandoned loads.
module write_back_unit
   import wb_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic             clk,
   input  logic             reset,
   write_back_unit_if.slave wb
);
   wb_state_e         state, state_nxt;
   logic              accept, cap_load;
   logic [REG_AW-1:0] ld_rd;
   logic [2:0]        ld_f3, ld_addr;
   logic              ld_rw;
   logic [XLEN-1:0]   ld_result;
   logic              ld_fault;
   logic [XLEN-1:0]   sel_value;

   logic              we_q, we_nxt;
   logic              fault_q, fault_nxt;
   logic              stray_q, stray_nxt;
   logic [REG_AW-1:0] waddr_q, waddr_nxt;
   logic [XLEN-1:0]   wdata_q, wdata_nxt;

   load_align #(.XLEN(XLEN)) u_load_align (
      .funct3   (ld_f3),
      .addr_low (ld_addr),
      .rsp_data (wb.mem_rsp_data),
      .result   (ld_result),
      .fault    (ld_fault)
   );

   assign wb.in_ready   = (state == IDLE);
   assign accept        = wb.in_valid && (state == IDLE) && !wb.flush;
   assign wb.rf_we      = we_q;
   assign wb.rf_waddr   = waddr_q;
   assign wb.rf_wdata   = wdata_q;
   assign wb.load_fault = fault_q;
   assign wb.stray_rsp  = stray_q;

   always_comb begin
      sel_value = '0;
      case (wb_sel_e'(wb.in_wb_sel))
         WB_ALU:  sel_value = wb.in_alu_result;
         WB_PC4:  sel_value = wb.in_pc_plus4;
         WB_IMM:  sel_value = wb.in_imm;
         default: sel_value = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cap_load  = 1'b0;
      we_nxt    = 1'b0;
      fault_nxt = 1'b0;
      stray_nxt = 1'b0;
      waddr_nxt = waddr_q;
      wdata_nxt = wdata_q;
      case (state)
         IDLE: begin
            stray_nxt = wb.mem_rsp_valid;
            if (accept) begin
               if (wb_sel_e'(wb.in_wb_sel) == WB_MEM) begin
                  cap_load  = 1'b1;
                  state_nxt = WAIT_MEM;
               end else begin
                  we_nxt    = wb.in_reg_write && (wb.in_rd != '0);
                  waddr_nxt = wb.in_rd;
                  wdata_nxt = sel_value;
               end
            end
         end
         WAIT_MEM: begin
            if (wb.mem_rsp_valid) begin
               state_nxt = IDLE;
               // A response that arrives with the flush belongs to the killed load.
               if (!wb.flush) begin
                  we_nxt    = ld_rw && (ld_rd != '0) && !ld_fault;
                  fault_nxt = ld_fault;
                  waddr_nxt = ld_rd;
                  wdata_nxt = ld_result;
               end
            end else if (wb.flush) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (wb.mem_rsp_valid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         fault_q <= 1'b0;
         stray_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         ld_rd   <= '0;
         ld_f3   <= '0;
         ld_addr <= '0;
         ld_rw   <= 1'b0;
      end else begin
         state   <= state_nxt;
         we_q    <= we_nxt;
         fault_q <= fault_nxt;
         stray_q <= stray_nxt;
         waddr_q <= waddr_nxt;
         wdata_q <= wdata_nxt;
         if (cap_load) begin
            ld_rd   <= wb.in_rd;
            ld_f3   <= wb.in_load_funct3;
            ld_addr <= wb.in_addr_low;
            ld_rw   <= wb.in_reg_write;
         end
      end
   end
endmodule
